// File: rtl/next_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package  : next_pc_unit_pkg
// Brief    : Shared select codes, branch funct3 encodings and BTB counter values.
// Revision : 1.0 - initial release
// ============================================================================
package next_pc_unit_pkg;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_TARGET = 2'b01;
  localparam logic [1:0] PC_SRC_JALR   = 2'b10;

  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef logic [1:0] ctr_t;

  // Saturating 2-bit direction counter step.
  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != CTR_ST) r = c + 2'd1;
    end else begin
      if (c != CTR_SNT) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Interface: next_pc_unit_if
// Brief    : Fetch-side prediction and execute-side resolution signals.
// Revision : 1.0 - initial release
// ============================================================================
interface next_pc_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [XLEN-1:0] pc_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_branch;
  logic            ex_jump;
  logic [2:0]      ex_funct3;
  logic            zero;
  logic            negative;
  logic            carry_out;
  logic            overflow;
  logic [XLEN-1:0] ex_target;
  logic [XLEN-1:0] ex_jalr_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            redirect_o;
  logic [1:0]      pc_src_o;

  modport slave (
    input  stall, ex_valid, ex_pc, ex_branch, ex_jump, ex_funct3,
           zero, negative, carry_out, overflow,
           ex_target, ex_jalr_target, ex_pred_taken, ex_pred_target,
    output pc_o, pred_taken_o, pred_target_o, redirect_o, pc_src_o
  );

  modport master (
    output stall, ex_valid, ex_pc, ex_branch, ex_jump, ex_funct3,
           zero, negative, carry_out, overflow,
           ex_target, ex_jalr_target, ex_pred_taken, ex_pred_target,
    input  pc_o, pred_taken_o, pred_target_o, redirect_o, pc_src_o
  );
endinterface
`default_nettype wire

// File: rtl/next_pc_unit_branch_cond.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_unit_branch_cond
// Brief    : Branch condition from funct3 and the ALU flags of (a - b).
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_unit_branch_cond
  import next_pc_unit_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_negative,
  input  logic       i_carry_out,
  input  logic       i_overflow,
  output logic       o_cond
);

  // carry_out of a - b is the inverted borrow, so it means a >= b unsigned.
  always_comb begin
    o_cond = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_cond = i_zero;
      F3_BNE:  o_cond = ~i_zero;
      F3_BLT:  o_cond = i_negative ^ i_overflow;
      F3_BGE:  o_cond = ~(i_negative ^ i_overflow);
      F3_BLTU: o_cond = ~i_carry_out;
      F3_BGEU: o_cond = i_carry_out;
      default: o_cond = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/next_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_unit
// Brief    : Fetch PC register, direct-mapped BTB with 2-bit counters, and
//            execute-stage branch resolution with misprediction redirect.
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [1:0]      CTR_INIT    = 2'b01
) (
  input  logic           clk,
  input  logic           rst_n,
  next_pc_unit_if.slave  bus
);

  localparam int              IDX_W   = $clog2(BTB_ENTRIES);
  localparam int              TAG_W   = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0]  r_pc;
  logic             r_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] r_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]  r_target [BTB_ENTRIES];
  ctr_t             r_ctr    [BTB_ENTRIES];

  logic             w_cond;
  logic [1:0]       w_pc_src;
  logic             w_taken;
  logic [XLEN-1:0]  w_jalr_tgt;
  logic [XLEN-1:0]  w_actual;
  logic             w_redirect;
  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic             w_pred_taken;
  logic [XLEN-1:0]  w_pred_target;
  logic [IDX_W-1:0] w_e_idx;
  logic [TAG_W-1:0] w_e_tag;
  logic             w_e_hit;
  logic             w_upd;
  ctr_t             w_ctr_next;

  next_pc_unit_branch_cond u_branch_cond (
    .i_funct3    (bus.ex_funct3),
    .i_zero      (bus.zero),
    .i_negative  (bus.negative),
    .i_carry_out (bus.carry_out),
    .i_overflow  (bus.overflow),
    .o_cond      (w_cond)
  );

  // Resolution of the execute-stage instruction.
  always_comb begin
    w_pc_src = PC_SRC_SEQ;
    if (bus.ex_valid) begin
      if (bus.ex_jump && (bus.ex_funct3 == F3_JALR)) begin
        w_pc_src = PC_SRC_JALR;
      end else if (bus.ex_jump || (bus.ex_branch && w_cond)) begin
        w_pc_src = PC_SRC_TARGET;
      end
    end
  end

  assign w_taken    = (w_pc_src != PC_SRC_SEQ);
  assign w_jalr_tgt = bus.ex_jalr_target & {{(XLEN-1){1'b1}}, 1'b0};

  always_comb begin
    w_actual = bus.ex_pc + PC_STEP;
    case (w_pc_src)
      PC_SRC_TARGET: w_actual = bus.ex_target;
      PC_SRC_JALR:   w_actual = w_jalr_tgt;
      default:       w_actual = bus.ex_pc + PC_STEP;
    endcase
  end

  assign w_redirect = rst_n & bus.ex_valid &
                      ((w_taken != bus.ex_pred_taken) |
                       (w_taken & (bus.ex_pred_target != w_actual)));

  // Fetch-side lookup reads the pre-update array contents.
  assign w_f_idx       = r_pc[IDX_W+1:2];
  assign w_f_tag       = r_pc[XLEN-1:IDX_W+2];
  assign w_f_hit       = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_pred_taken  = rst_n & w_f_hit & r_ctr[w_f_idx][1];
  assign w_pred_target = !rst_n      ? (RESET_PC + PC_STEP) :
                         w_pred_taken ? r_target[w_f_idx]   :
                                        (r_pc + PC_STEP);

  assign w_e_idx    = bus.ex_pc[IDX_W+1:2];
  assign w_e_tag    = bus.ex_pc[XLEN-1:IDX_W+2];
  assign w_e_hit    = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
  assign w_upd      = bus.ex_valid & (bus.ex_branch | bus.ex_jump);
  assign w_ctr_next = bus.ex_jump ? CTR_ST : ctr_step(r_ctr[w_e_idx], w_taken);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_actual;
    end else if (!bus.stall) begin
      r_pc <= w_pred_target;
    end
  end

  // BTB training ignores stall; tag and target need no reset behind valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_INIT;
      end
    end else if (w_upd) begin
      if (w_e_hit) begin
        r_ctr[w_e_idx] <= w_ctr_next;
        if (w_taken) r_target[w_e_idx] <= w_actual;
      end else if (w_taken) begin
        r_valid[w_e_idx]  <= 1'b1;
        r_tag[w_e_idx]    <= w_e_tag;
        r_target[w_e_idx] <= w_actual;
        r_ctr[w_e_idx]    <= bus.ex_jump ? CTR_ST : CTR_WT;
      end
    end
  end

  assign bus.pc_o          = r_pc;
  assign bus.pred_taken_o  = w_pred_taken;
  assign bus.pred_target_o = w_pred_target;
  assign bus.redirect_o    = w_redirect;
  assign bus.pc_src_o      = w_pc_src;

endmodule
`default_nettype wire

// File: tb/tb_next_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_next_pc_unit
// Brief    : Directed scenarios plus randomized traffic against a BTB/PC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_next_pc_unit;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam logic [31:0] HELPER_PC = 32'h7F0;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] op_a;
  logic [31:0] op_b;

  next_pc_unit_if #(.XLEN(32)) bus ();

  next_pc_unit #(
    .XLEN        (32),
    .BTB_ENTRIES (16),
    .RESET_PC    (RST_PC),
    .CTR_INIT    (2'b01)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: table of 16 slots, counters as plain integers.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_pc = RST_PC;

  logic        e_pred_taken;
  logic [31:0] e_pred_target;
  logic        e_redirect;
  logic [1:0]  e_pc_src;
  logic [31:0] e_actual;
  bit          e_taken;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd16);
  endfunction

  function automatic bit m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_comb();
    int s;
    s = slot(m_pc);
    e_pc_src = 2'd0;
    if (bus.ex_valid) begin
      if (bus.ex_jump && bus.ex_funct3 == 3'd0) e_pc_src = 2'd2;
      else if (bus.ex_jump || (bus.ex_branch && m_cond(bus.ex_funct3, op_a, op_b))) e_pc_src = 2'd1;
    end
    e_taken  = (e_pc_src != 2'd0);
    e_actual = (e_pc_src == 2'd2) ? (bus.ex_jalr_target / 32'd2) * 32'd2 :
               (e_pc_src == 2'd1) ? bus.ex_target : bus.ex_pc + 32'd4;
    e_redirect = rst_n && bus.ex_valid &&
                 ((e_taken != bus.ex_pred_taken) || (e_taken && bus.ex_pred_target != e_actual));
    e_pred_taken  = rst_n && m_valid[s] && (m_tag[s] == m_pc / 32'd64) && (m_ctr[s] >= 2);
    e_pred_target = !rst_n ? RST_PC + 32'd4 : (e_pred_taken ? m_tgt[s] : m_pc + 32'd4);
  endtask

  task automatic model_seq();
    int s;
    bit hit;
    if (!rst_n) begin
      m_pc = RST_PC;
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
    end else begin
      s   = slot(bus.ex_pc);
      hit = m_valid[s] && (m_tag[s] == bus.ex_pc / 32'd64);
      if (bus.ex_valid && (bus.ex_branch || bus.ex_jump)) begin
        if (hit) begin
          if (bus.ex_jump) m_ctr[s] = 3;
          else if (e_taken) m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          else m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
          if (e_taken) m_tgt[s] = e_actual;
        end else if (e_taken) begin
          m_valid[s] = 1'b1;
          m_tag[s]   = bus.ex_pc / 32'd64;
          m_tgt[s]   = e_actual;
          m_ctr[s]   = bus.ex_jump ? 3 : 2;
        end
      end
      if (e_redirect) m_pc = e_actual;
      else if (!bus.stall) m_pc = e_pred_target;
    end
  endtask

  // Stimulus helpers (no checking inside).
  task automatic tick();
    model_comb();
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    op_a = a;
    op_b = b;
    s = {1'b0, a} + {1'b0, ~b} + 33'd1;
    bus.carry_out = s[32];
    bus.negative  = s[31];
    bus.zero      = (s[31:0] == 32'd0);
    bus.overflow  = (a[31] != b[31]) && (s[31] != a[31]);
  endtask

  task automatic clear_ex();
    bus.ex_valid       = 1'b0;
    bus.ex_pc          = 32'h0;
    bus.ex_branch      = 1'b0;
    bus.ex_jump        = 1'b0;
    bus.ex_funct3      = 3'd0;
    bus.ex_target      = 32'h0;
    bus.ex_jalr_target = 32'h0;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = 32'h0;
  endtask

  task automatic redirect_to(input logic [31:0] addr);
    bus.ex_valid       = 1'b1;
    bus.ex_jump        = 1'b1;
    bus.ex_branch      = 1'b0;
    bus.ex_funct3      = 3'd1;
    bus.ex_pc          = HELPER_PC;
    bus.ex_target      = addr;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = HELPER_PC + 32'd4;
    tick();
    clear_ex();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.ex_valid = 1'b1; bus.ex_jump = 1'b1; bus.ex_funct3 = 3'd1;
    bus.ex_pc = 32'h900; bus.ex_target = 32'h500;
    #1;
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b expected 0", bus.redirect_o); end
    checks++; if (bus.pred_target_o !== 32'h104) begin errors++; $display("FAIL reset_pred_target: got %h expected 00000104", bus.pred_target_o); end
    tick();
    #1;
    checks++; if (bus.pc_o !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h expected 00000100", bus.pc_o); end
    checks++; if (bus.pred_taken_o !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b expected 0", bus.pred_taken_o); end
    tick();
    rst_n = 1'b1;
    clear_ex();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.pc_o !== RST_PC + 32'(4 * k)) begin errors++; $display("FAIL seq_pc%0d: got %h expected %h", k, bus.pc_o, RST_PC + 32'(4 * k)); end
      checks++; if (bus.pred_taken_o !== 1'b0) begin errors++; $display("FAIL seq_pred%0d: got %b expected 0", k, bus.pred_taken_o); end
      tick();
    end
  endtask

  task automatic test_mispredict();
    bus.ex_valid = 1'b1; bus.ex_branch = 1'b1; bus.ex_funct3 = 3'b000;
    set_ops(32'd5, 32'd5);
    bus.ex_pc = 32'h200; bus.ex_target = 32'h240;
    bus.ex_pred_taken = 1'b0; bus.ex_pred_target = 32'h204;
    #1;
    checks++; if (bus.redirect_o !== 1'b1) begin errors++; $display("FAIL beq_redirect: got %b expected 1", bus.redirect_o); end
    checks++; if (bus.pc_src_o !== 2'b01) begin errors++; $display("FAIL beq_pc_src: got %b expected 01", bus.pc_src_o); end
    tick();
    clear_ex();
    #1;
    checks++; if (bus.pc_o !== 32'h240) begin errors++; $display("FAIL beq_next_pc: got %h expected 00000240", bus.pc_o); end
    redirect_to(32'h200);
    #1;
    checks++; if (bus.pred_taken_o !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken: got %b expected 1", bus.pred_taken_o); end
    checks++; if (bus.pred_target_o !== 32'h240) begin errors++; $display("FAIL alloc_pred_target: got %h expected 00000240", bus.pred_target_o); end
  endtask

  task automatic test_jalr();
    bus.ex_valid = 1'b1; bus.ex_jump = 1'b1; bus.ex_funct3 = 3'b000;
    bus.ex_pc = 32'h284; bus.ex_jalr_target = 32'h301; bus.ex_target = 32'h999;
    bus.ex_pred_taken = 1'b0; bus.ex_pred_target = 32'h288;
    #1;
    checks++; if (bus.pc_src_o !== 2'b10) begin errors++; $display("FAIL jalr_pc_src: got %b expected 10", bus.pc_src_o); end
    checks++; if (bus.redirect_o !== 1'b1) begin errors++; $display("FAIL jalr_redirect: got %b expected 1", bus.redirect_o); end
    tick();
    clear_ex();
    #1;
    checks++; if (bus.pc_o !== 32'h300) begin errors++; $display("FAIL jalr_next_pc: got %h expected 00000300", bus.pc_o); end
    redirect_to(32'h284);
    #1;
    checks++; if (bus.pred_taken_o !== 1'b1) begin errors++; $display("FAIL jalr_pred_taken: got %b expected 1", bus.pred_taken_o); end
    checks++; if (bus.pred_target_o !== 32'h300) begin errors++; $display("FAIL jalr_pred_target: got %h expected 00000300", bus.pred_target_o); end
  endtask

  task automatic test_counter_training();
    // Entry at 0x284 starts strongly taken; fetch PC is 0x284 here.
    for (int k = 0; k < 2; k++) begin
      bus.ex_valid = 1'b1; bus.ex_branch = 1'b1; bus.ex_funct3 = 3'b110;
      set_ops(32'd9, 32'd3);
      bus.ex_pc = 32'h284; bus.ex_target = 32'h300;
      bus.ex_pred_taken = 1'b1; bus.ex_pred_target = 32'h300;
      #1;
      checks++; if (bus.pred_taken_o !== 1'b1) begin errors++; $display("FAIL bltu_pre_pred%0d: got %b expected 1", k, bus.pred_taken_o); end
      checks++; if (bus.redirect_o !== 1'b1) begin errors++; $display("FAIL bltu_redirect%0d: got %b expected 1", k, bus.redirect_o); end
      checks++; if (bus.pc_src_o !== 2'b00) begin errors++; $display("FAIL bltu_pc_src%0d: got %b expected 00", k, bus.pc_src_o); end
      tick();
      clear_ex();
      #1;
      checks++; if (bus.pc_o !== 32'h288) begin errors++; $display("FAIL bltu_next_pc%0d: got %h expected 00000288", k, bus.pc_o); end
      redirect_to(32'h284);
    end
    #1;
    checks++; if (bus.pred_taken_o !== 1'b0) begin errors++; $display("FAIL bltu_trained_pred: got %b expected 0", bus.pred_taken_o); end
    checks++; if (bus.pred_target_o !== 32'h288) begin errors++; $display("FAIL bltu_trained_target: got %h expected 00000288", bus.pred_target_o); end
    bus.ex_valid = 1'b1; bus.ex_branch = 1'b1; bus.ex_funct3 = 3'b110;
    set_ops(32'd9, 32'd3);
    bus.ex_pc = 32'h284; bus.ex_target = 32'h300;
    bus.ex_pred_taken = 1'b0; bus.ex_pred_target = 32'h288;
    #1;
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL bltu_correct_redirect: got %b expected 0", bus.redirect_o); end
    tick();
    clear_ex();
    #1;
    checks++; if (bus.pc_o !== 32'h288) begin errors++; $display("FAIL bltu_correct_pc: got %h expected 00000288", bus.pc_o); end
  endtask

  task automatic test_stall_redirect();
    bus.stall = 1'b1;
    bus.ex_valid = 1'b1; bus.ex_branch = 1'b1; bus.ex_funct3 = 3'b001;
    set_ops(32'd1, 32'd2);
    bus.ex_pc = 32'h3F0; bus.ex_target = 32'h400;
    bus.ex_pred_taken = 1'b0; bus.ex_pred_target = 32'h3F4;
    #1;
    checks++; if (bus.redirect_o !== 1'b1) begin errors++; $display("FAIL stall_redirect: got %b expected 1", bus.redirect_o); end
    tick();
    clear_ex();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.pc_o !== 32'h400) begin errors++; $display("FAIL stall_hold%0d: got %h expected 00000400", k, bus.pc_o); end
      tick();
    end
    bus.stall = 1'b0;
    tick();
    #1;
    checks++; if (bus.pc_o !== 32'h404) begin errors++; $display("FAIL stall_release: got %h expected 00000404", bus.pc_o); end
  endtask

  task automatic test_wrap();
    redirect_to(32'hFFFF_FFFC);
    #1;
    checks++; if (bus.pred_target_o !== 32'h0) begin errors++; $display("FAIL wrap_pred_target: got %h expected 00000000", bus.pred_target_o); end
    tick();
    #1;
    checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 00000000", bus.pc_o); end
  endtask

  task automatic test_reset_midrun();
    redirect_to(32'h200);
    #1;
    checks++; if (bus.pred_taken_o !== 1'b1) begin errors++; $display("FAIL pre_reset_pred: got %b expected 1", bus.pred_taken_o); end
    rst_n = 1'b0;
    bus.ex_valid = 1'b1; bus.ex_jump = 1'b1; bus.ex_funct3 = 3'd1;
    bus.ex_pc = 32'h900; bus.ex_target = 32'h500;
    bus.ex_pred_taken = 1'b0; bus.ex_pred_target = 32'h904;
    #1;
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL midreset_redirect: got %b expected 0", bus.redirect_o); end
    tick();
    rst_n = 1'b1;
    clear_ex();
    #1;
    checks++; if (bus.pc_o !== RST_PC) begin errors++; $display("FAIL midreset_pc: got %h expected %h", bus.pc_o, RST_PC); end
    redirect_to(32'h200);
    #1;
    checks++; if (bus.pred_taken_o !== 1'b0) begin errors++; $display("FAIL post_reset_pred: got %b expected 0", bus.pred_taken_o); end
    checks++; if (bus.pred_target_o !== 32'h204) begin errors++; $display("FAIL post_reset_target: got %h expected 00000204", bus.pred_target_o); end
    redirect_to(32'h900);
    #1;
    checks++; if (bus.pred_taken_o !== 1'b0) begin errors++; $display("FAIL discarded_update_pred: got %b expected 0", bus.pred_taken_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int kind;
      rst_n     = ($urandom_range(0, 63) != 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      kind      = $urandom_range(0, 3);
      bus.ex_valid  = (kind != 0);
      bus.ex_branch = (kind == 1);
      bus.ex_jump   = (kind == 2);
      bus.ex_funct3 = 3'($urandom_range(0, 7));
      bus.ex_pc     = ($urandom_range(0, 15) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                                   : 32'h1000 + 32'(4 * $urandom_range(0, 31));
      bus.ex_target      = 32'h1000 + 32'(4 * $urandom_range(0, 31));
      bus.ex_jalr_target = 32'h1000 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 1));
      op_a = $urandom();
      op_b = ($urandom_range(0, 1) == 0) ? op_a : $urandom();
      if ($urandom_range(0, 3) == 0) op_b = op_a ^ 32'h8000_0000;
      set_ops(op_a, op_b);
      bus.ex_pred_taken = 1'b0; bus.ex_pred_target = 32'h0;
      model_comb();
      bus.ex_pred_taken  = ($urandom_range(0, 2) != 0) ? e_taken : 1'($urandom_range(0, 1));
      bus.ex_pred_target = ($urandom_range(0, 3) != 0) ? e_actual : 32'h1000 + 32'(4 * $urandom_range(0, 31));
      model_comb();
      #1;
      checks++; if (bus.pc_o !== m_pc) begin errors++; $display("FAIL rnd%0d pc: got %h expected %h", n, bus.pc_o, m_pc); end
      checks++; if (bus.pred_taken_o !== e_pred_taken) begin errors++; $display("FAIL rnd%0d pred_taken: got %b expected %b", n, bus.pred_taken_o, e_pred_taken); end
      checks++; if (bus.pred_target_o !== e_pred_target) begin errors++; $display("FAIL rnd%0d pred_target: got %h expected %h", n, bus.pred_target_o, e_pred_target); end
      checks++; if (bus.redirect_o !== e_redirect) begin errors++; $display("FAIL rnd%0d redirect: got %b expected %b", n, bus.redirect_o, e_redirect); end
      checks++; if (bus.pc_src_o !== e_pc_src) begin errors++; $display("FAIL rnd%0d pc_src: got %b expected %b", n, bus.pc_src_o, e_pc_src); end
      tick();
    end
    rst_n = 1'b1;
    clear_ex();
  endtask

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b0;
    checks = 0;
    errors = 0;
    bus.stall = 1'b0;
    clear_ex();
    set_ops(32'd0, 32'd0);
    test_reset();
    test_mispredict();
    test_jalr();
    test_counter_training();
    test_stall_redirect();
    test_wrap();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
